// File: rtl/mac_dot_sequencer.sv
// Purpose : operand sequencer for the 16-bit MAC; streams (a,b) pairs into it, clears it per vector,
//           and returns each 36-bit dot product on a valid/ready result port.
// Latency : last pair accepted at edge t -> res_valid high after edge t+MAC_LAT+2.
// Backpres: in_ready drops while a vector drains or its result waits; a stalled result holds all outputs.
//
// Ports
//   clk, reset                  rising-edge clock, asynchronous active-low reset
//   in_valid/in_ready           operand pair handshake; in_a, in_b unsigned 16-bit, in_last ends a vector
//   mac_a, mac_b, mac_clr       drive the external MAC (mac_clr high clears its accumulator)
//   mac_out                     36-bit accumulator value returned by the MAC
//   res_valid/res_ready         result handshake; res_data dot product, res_len pair count,
//                               res_ovf set on length truncation (or clamp when saturation is built in)
//
// Build option: define MAC_SEQ_SAT_EN to clamp res_data to 2^SAT_W-1 (and flag res_ovf) on capture.
module mac_dot_sequencer #(
  parameter int MAX_LEN = 16,
  parameter int MAC_LAT = 1,
  parameter int SAT_W   = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_a,
  input  logic [15:0] in_b,
  input  logic        in_last,
  output logic [15:0] mac_a,
  output logic [15:0] mac_b,
  output logic        mac_clr,
  input  logic [35:0] mac_out,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [35:0] res_data,
  output logic [4:0]  res_len,
  output logic        res_ovf
);

  typedef enum logic [1:0] {
    S_CLEAR = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_HOLD  = 2'd3
  } state_t;

  // Drain covers the operand register plus the MAC's own pipeline.
  localparam int              DRN_W    = $clog2(MAC_LAT + 2);
  localparam logic [DRN_W-1:0] DRN_LOAD = DRN_W'(MAC_LAT + 1);
  localparam logic [4:0]       MAX_CNT  = 5'(MAX_LEN);

`ifdef MAC_SEQ_SAT_EN
  localparam logic SAT_ON = 1'b1;
`else
  localparam logic SAT_ON = 1'b0;
`endif

  // One extra bit so SAT_W up to 36 still yields a representable limit.
  localparam logic [36:0] SAT_LIM = 37'd1 << SAT_W;
  localparam logic [35:0] SAT_MAX = 36'(SAT_LIM - 37'd1);

  state_t           r_state;
  logic             r_in_ready;
  logic [15:0]      r_mac_a;
  logic [15:0]      r_mac_b;
  logic             r_mac_clr;
  logic             r_res_valid;
  logic [35:0]      r_res_data;
  logic [4:0]       r_res_len;
  logic             r_res_ovf;
  logic [4:0]       r_count;
  logic             r_trunc;
  logic [DRN_W-1:0] r_drn_cnt;

  state_t           w_state_nxt;
  logic             w_in_ready_nxt;
  logic [15:0]      w_mac_a_nxt;
  logic [15:0]      w_mac_b_nxt;
  logic             w_mac_clr_nxt;
  logic             w_res_valid_nxt;
  logic [35:0]      w_res_data_nxt;
  logic [4:0]       w_res_len_nxt;
  logic             w_res_ovf_nxt;
  logic [4:0]       w_count_nxt;
  logic             w_trunc_nxt;
  logic [DRN_W-1:0] w_drn_cnt_nxt;

  logic             w_accept;
  logic [4:0]       w_count_inc;
  logic             w_at_max;
  logic             w_sat_hit;

  // r_in_ready is only ever high in RUN, so it alone qualifies an accept.
  assign w_accept    = in_valid & r_in_ready;
  assign w_count_inc = r_count + 5'd1;
  assign w_at_max    = (w_count_inc == MAX_CNT);
  assign w_sat_hit   = SAT_ON & ({1'b0, mac_out} >= SAT_LIM);

  always_comb begin
    w_state_nxt     = r_state;
    w_in_ready_nxt  = r_in_ready;
    w_mac_a_nxt     = r_mac_a;
    w_mac_b_nxt     = r_mac_b;
    w_mac_clr_nxt   = r_mac_clr;
    w_res_valid_nxt = r_res_valid;
    w_res_data_nxt  = r_res_data;
    w_res_len_nxt   = r_res_len;
    w_res_ovf_nxt   = r_res_ovf;
    w_count_nxt     = r_count;
    w_trunc_nxt     = r_trunc;
    w_drn_cnt_nxt   = r_drn_cnt;

    case (r_state)
      S_CLEAR: begin
        // The clear pulse has been presented for this cycle; open the input next.
        w_state_nxt    = S_RUN;
        w_mac_clr_nxt  = 1'b0;
        w_in_ready_nxt = 1'b1;
        w_mac_a_nxt    = 16'd0;
        w_mac_b_nxt    = 16'd0;
      end

      S_RUN: begin
        // Idle cycles feed a zero product so bubbles leave the accumulator alone.
        w_mac_a_nxt = 16'd0;
        w_mac_b_nxt = 16'd0;
        if (w_accept) begin
          w_mac_a_nxt = in_a;
          w_mac_b_nxt = in_b;
          w_count_nxt = w_count_inc;
          if (in_last || w_at_max) begin
            w_state_nxt    = S_DRAIN;
            w_in_ready_nxt = 1'b0;
            w_trunc_nxt    = ~in_last;
            w_drn_cnt_nxt  = DRN_LOAD;
          end
        end
      end

      S_DRAIN: begin
        w_mac_a_nxt = 16'd0;
        w_mac_b_nxt = 16'd0;
        if (r_drn_cnt == '0) begin
          w_state_nxt     = S_HOLD;
          w_res_valid_nxt = 1'b1;
          w_res_len_nxt   = r_count;
          w_res_data_nxt  = w_sat_hit ? SAT_MAX : mac_out;
          w_res_ovf_nxt   = r_trunc | w_sat_hit;
        end else begin
          w_drn_cnt_nxt = r_drn_cnt - DRN_W'(1);
        end
      end

      S_HOLD: begin
        if (res_ready) begin
          w_state_nxt     = S_CLEAR;
          w_res_valid_nxt = 1'b0;
          w_count_nxt     = 5'd0;
          w_trunc_nxt     = 1'b0;
          w_mac_clr_nxt   = 1'b1;
        end
      end

      default: begin
        w_state_nxt    = S_CLEAR;
        w_mac_clr_nxt  = 1'b1;
        w_in_ready_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_CLEAR;
      r_in_ready  <= 1'b0;
      r_mac_a     <= 16'd0;
      r_mac_b     <= 16'd0;
      r_mac_clr   <= 1'b1;
      r_res_valid <= 1'b0;
      r_res_data  <= 36'd0;
      r_res_len   <= 5'd0;
      r_res_ovf   <= 1'b0;
      r_count     <= 5'd0;
      r_trunc     <= 1'b0;
      r_drn_cnt   <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_in_ready  <= w_in_ready_nxt;
      r_mac_a     <= w_mac_a_nxt;
      r_mac_b     <= w_mac_b_nxt;
      r_mac_clr   <= w_mac_clr_nxt;
      r_res_valid <= w_res_valid_nxt;
      r_res_data  <= w_res_data_nxt;
      r_res_len   <= w_res_len_nxt;
      r_res_ovf   <= w_res_ovf_nxt;
      r_count     <= w_count_nxt;
      r_trunc     <= w_trunc_nxt;
      r_drn_cnt   <= w_drn_cnt_nxt;
    end
  end

  assign in_ready  = r_in_ready;
  assign mac_a     = r_mac_a;
  assign mac_b     = r_mac_b;
  assign mac_clr   = r_mac_clr;
  assign res_valid = r_res_valid;
  assign res_data  = r_res_data;
  assign res_len   = r_res_len;
  assign res_ovf   = r_res_ovf;

endmodule

// File: tb/tb_mac_dot_sequencer.sv
// Purpose : directed bench for mac_dot_sequencer with a one-stage MAC model beside it.
// Latency : expects res_valid three edges after the last accepted pair.
// Backpres: exercises stalled results, bubbles, truncation and mid-vector reset.
module tb_mac_dot_sequencer;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_a;
  logic [15:0] in_b;
  logic        in_last;
  logic [15:0] mac_a;
  logic [15:0] mac_b;
  logic        mac_clr;
  logic [35:0] mac_out;
  logic        res_valid;
  logic        res_ready;
  logic [35:0] res_data;
  logic [4:0]  res_len;
  logic        res_ovf;

  logic [35:0] acc;
  int          checks = 0;
  int          errors = 0;

  mac_dot_sequencer dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_a     (in_a),
    .in_b     (in_b),
    .in_last  (in_last),
    .mac_a    (mac_a),
    .mac_b    (mac_b),
    .mac_clr  (mac_clr),
    .mac_out  (mac_out),
    .res_valid(res_valid),
    .res_ready(res_ready),
    .res_data (res_data),
    .res_len  (res_len),
    .res_ovf  (res_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // MAC model: single accumulator register, cleared synchronously by mac_clr.
  always @(posedge clk) begin
    if (mac_clr) acc <= 36'd0;
    else         acc <= acc + 36'(mac_a) * 36'(mac_b);
  end
  assign mac_out = acc;

  task automatic chk(input string tag, input logic [35:0] obs, input logic [35:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic send(input logic [15:0] a, input logic [15:0] b, input logic l);
    int n;
    n = 0;
    in_valid = 1'b1; in_a = a; in_b = b; in_last = l;
    while (in_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("send_ready", {35'd0, in_ready}, 36'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic wait_res(output int cyc);
    cyc = 0;
    while (res_valid !== 1'b1 && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    chk("res_timeout", {35'd0, res_valid}, 36'd1);
  endtask

  task automatic take_res(input string tag);
    res_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    res_ready = 1'b0;
    chk(tag, {35'd0, res_valid}, 36'd0);
  endtask

  initial begin
    int cyc;
    int seen;
    reset = 1'b0; in_valid = 1'b0; in_a = 16'd0; in_b = 16'd0; in_last = 1'b0; res_ready = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state
    chk("rst_clr",   {35'd0, mac_clr},   36'd1);
    chk("rst_rdy",   {35'd0, in_ready},  36'd0);
    chk("rst_vld",   {35'd0, res_valid}, 36'd0);
    chk("rst_data",  res_data,           36'd0);
    chk("rst_len",   {31'd0, res_len},   36'd0);
    chk("rst_ovf",   {35'd0, res_ovf},   36'd0);
    chk("rst_maca",  {20'd0, mac_a},     36'd0);
    reset = 1'b1;

    // 1: back-to-back pairs, 12+30+56
    send(16'd3, 16'd4, 1'b0);
    chk("t1_maca", {20'd0, mac_a}, 36'd3);
    chk("t1_macb", {20'd0, mac_b}, 36'd4);
    send(16'd5, 16'd6, 1'b0);
    send(16'd7, 16'd8, 1'b1);
    wait_res(cyc);
    chk("t1_latency", 36'(cyc), 36'd3);
    chk("t1_data", res_data, 36'd98);
    chk("t1_len",  {31'd0, res_len}, 36'd3);
    chk("t1_ovf",  {35'd0, res_ovf}, 36'd0);
    take_res("t1_release");

    // 2: two-cycle bubbles between pairs; res_ready pulses while idle are ignored
    send(16'd3, 16'd4, 1'b0);
    res_ready = 1'b1;
    repeat (2) @(negedge clk);
    res_ready = 1'b0;
    chk("t2_bubble_maca", {20'd0, mac_a}, 36'd0);
    send(16'd5, 16'd6, 1'b0);
    repeat (2) @(negedge clk);
    send(16'd7, 16'd8, 1'b1);
    wait_res(cyc);
    chk("t2_data", res_data, 36'd98);
    chk("t2_len",  {31'd0, res_len}, 36'd3);
    take_res("t2_release");

    // 3: 17 max-value pairs; truncation at 16, 17th forms its own vector
    for (int i = 0; i < 16; i++) send(16'hFFFF, 16'hFFFF, 1'b0);
    in_valid = 1'b1; in_a = 16'hFFFF; in_b = 16'hFFFF; in_last = 1'b1;
    wait_res(cyc);
    chk("t3_rdy_low", {35'd0, in_ready}, 36'd0);
`ifdef MAC_SEQ_SAT_EN
    chk("t3_data", res_data, 36'h0FFFFFFFF);
`else
    chk("t3_data", res_data, 36'hFFFE00010);
`endif
    chk("t3_len", {31'd0, res_len}, 36'd16);
    chk("t3_ovf", {35'd0, res_ovf}, 36'd1);
    take_res("t3_release");
    cyc = 0;
    while (in_ready !== 1'b1 && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    chk("t3_reopen", {35'd0, in_ready}, 36'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0; in_last = 1'b0;
    wait_res(cyc);
    chk("t3b_data", res_data, 36'h0FFFE0001);
    chk("t3b_len",  {31'd0, res_len}, 36'd1);
    chk("t3b_ovf",  {35'd0, res_ovf}, 36'd0);
    take_res("t3b_release");

    // 4: result stalled five cycles, then accumulator must be clean
    send(16'd9, 16'd9, 1'b1);
    wait_res(cyc);
    for (int i = 0; i < 5; i++) begin
      chk("t4_hold_data", res_data, 36'd81);
      chk("t4_hold_len",  {31'd0, res_len}, 36'd1);
      chk("t4_hold_vld",  {35'd0, res_valid}, 36'd1);
      chk("t4_hold_rdy",  {35'd0, in_ready}, 36'd0);
      @(negedge clk);
    end
    take_res("t4_release");
    send(16'd2, 16'd2, 1'b1);
    wait_res(cyc);
    chk("t4_next_data", res_data, 36'd4);
    chk("t4_next_len",  {31'd0, res_len}, 36'd1);
    take_res("t4_next_release");

    // 5: reset mid-vector discards it
    send(16'd3, 16'd4, 1'b0);
    send(16'd5, 16'd6, 1'b0);
    reset = 1'b0;
    @(negedge clk);
    chk("t5_rst_clr", {35'd0, mac_clr},  36'd1);
    chk("t5_rst_rdy", {35'd0, in_ready}, 36'd0);
    reset = 1'b1;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      if (res_valid !== 1'b0) seen++;
      @(negedge clk);
    end
    chk("t5_no_result", 36'(seen), 36'd0);
    send(16'd1, 16'd1, 1'b1);
    wait_res(cyc);
    chk("t5_data", res_data, 36'd1);
    chk("t5_len",  {31'd0, res_len}, 36'd1);
    take_res("t5_release");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
